// File: rtl/m68k_bgctl_pkg.sv
// m68k_bgctl_pkg: state encoding and per-state output constants for the bus-grant responder
package m68k_bgctl_pkg;
    typedef enum logic [2:0] {
        OWN      = 3'd0,
        WAIT     = 3'd1,
        GRANT    = 3'd2,
        RELEASED = 3'd3,
        RECOVER  = 3'd4
    } state_t;
    localparam logic [2:0] OUT_OWN      = 3'b101;
    localparam logic [2:0] OUT_WAIT     = 3'b111;
    localparam logic [2:0] OUT_GRANT    = 3'b010;
    localparam logic [2:0] OUT_RELEASED = 3'b110;
    localparam logic [2:0] OUT_RECOVER  = 3'b110;
    function automatic logic [2:0] state_out(state_t s);
        return s == OWN ? OUT_OWN : s == WAIT ? OUT_WAIT : s == GRANT ? OUT_GRANT :
               s == RELEASED ? OUT_RELEASED : OUT_RECOVER;
    endfunction
endpackage

// File: rtl/bgctl_sync.sv
// bgctl_sync: STAGES-deep input synchroniser that resets to the inactive (high) level
module bgctl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetl,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sh;
    // shift the pin into the chain; oldest sample drives q
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) sh <= '1;
        else sh <= STAGES'({sh, d});
    end
    assign q = sh[STAGES-1];
endmodule

// File: rtl/m68k_bgctl.sv
// m68k_bgctl: 68000 BR/BG/BGACK bus-grant responder; define BGCTL_TIMEOUT_EN to abandon unacknowledged grants
module m68k_bgctl
    import m68k_bgctl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RECOVER_CYC = 1,
    parameter int BG_TIMEOUT  = 15
) (
    input  logic clk,
    input  logic resetl,
    input  logic brl,
    input  logic bgackl,
    input  logic cpu_busy,
`ifdef BGCTL_TIMEOUT_EN
    output logic tmo,
`endif
    output logic bgl,
    output logic cpu_hold,
    output logic cpu_own
);
    localparam logic [2:0] RC = 3'(RECOVER_CYC - 1);
    state_t state, next_state;
    logic br_q, bgack_q, br_s, bgack_s, timeout;
    logic [2:0] rcnt;
    bgctl_sync #(.STAGES(SYNC_STAGES)) u_br_sync (.clk(clk), .resetl(resetl), .d(brl), .q(br_q));
    bgctl_sync #(.STAGES(SYNC_STAGES)) u_bgack_sync (.clk(clk), .resetl(resetl), .d(bgackl), .q(bgack_q));
    assign br_s    = ~br_q;
    assign bgack_s = ~bgack_q;
`ifdef BGCTL_TIMEOUT_EN
    localparam int TW = $clog2(BG_TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    assign timeout = state == GRANT && !bgack_s && br_s && tcnt == TW'(BG_TIMEOUT - 1);
    // age of the current grant; restarts on every entry and whenever the grant is left
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) tcnt <= '0;
        else tcnt <= (state == GRANT && next_state == GRANT) ? tcnt + 1'b1 : '0;
    end
    // one-cycle pulse on the edge that abandons the grant
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) tmo <= 1'b0;
        else tmo <= timeout;
    end
`else
    assign timeout = 1'b0;
`endif
    // next-state decode; an acknowledge outranks a withdrawn request in GRANT
    always_comb begin
        next_state = state;
        case (state)
            OWN:      next_state = !br_s ? OWN : bgack_s ? RELEASED : cpu_busy ? WAIT : GRANT;
            WAIT:     next_state = !br_s ? OWN : cpu_busy ? WAIT : GRANT;
            GRANT:    next_state = bgack_s ? RELEASED : (!br_s || timeout) ? OWN : GRANT;
            RELEASED: next_state = bgack_s ? RELEASED : RECOVER;
            RECOVER:  next_state = rcnt != 3'd0 ? RECOVER : br_s ? GRANT : OWN;
            default:  next_state = OWN;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) state <= OWN;
        else state <= next_state;
    end
    // idle countdown after the alternate master lets go
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) rcnt <= '0;
        else if (next_state == RECOVER) rcnt <= state == RECOVER ? rcnt - 1'b1 : RC;
    end
    // outputs registered from next_state so they move on the same edge as the state
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) {bgl, cpu_hold, cpu_own} <= OUT_OWN;
        else {bgl, cpu_hold, cpu_own} <= state_out(next_state);
    end
endmodule

// File: tb/tb_m68k_bgctl.sv
// tb_m68k_bgctl: directed and randomized checks of the bus-grant responder against a behavioural model
module tb_m68k_bgctl;
    localparam int SYNC_STAGES = 2;
    localparam int RECOVER_CYC = 3;
    localparam int BG_TIMEOUT  = 15;
    localparam int M_CPU = 0, M_CPU_HELD = 1, M_GRANTED = 2, M_OTHER = 3, M_RECOVER = 4;

    logic clk = 1'b0, resetl = 1'b0, brl = 1'b1, bgackl = 1'b1, cpu_busy = 1'b0;
    logic bgl, cpu_hold, cpu_own;
    logic tmo_obs;
`ifdef BGCTL_TIMEOUT_EN
    logic tmo;
    assign tmo_obs = tmo;
`else
    assign tmo_obs = 1'b0;
`endif
    int n_checks = 0, n_fail = 0;

    // model state: who holds the bus, how long the grant has been out, idle cycles still owed
    int mode, age, idle_left;
    bit br_d [SYNC_STAGES];
    bit bg_d [SYNC_STAGES];
    logic e_bgl, e_hold, e_own, e_tmo;

    always #5 clk = ~clk;

    m68k_bgctl #(.SYNC_STAGES(SYNC_STAGES), .RECOVER_CYC(RECOVER_CYC), .BG_TIMEOUT(BG_TIMEOUT)) dut (
        .clk(clk), .resetl(resetl), .brl(brl), .bgackl(bgackl), .cpu_busy(cpu_busy),
`ifdef BGCTL_TIMEOUT_EN
        .tmo(tmo),
`endif
        .bgl(bgl), .cpu_hold(cpu_hold), .cpu_own(cpu_own)
    );

    function automatic logic [2:0] mode_pins(int m);
        // {bgl, cpu_hold, cpu_own}: bgl low only while granted, CPU drives only when it owns the bus
        logic g, h, o;
        g = (m == M_GRANTED) ? 1'b0 : 1'b1;
        o = (m == M_CPU || m == M_CPU_HELD);
        h = (m != M_CPU);
        return {g, h, o};
    endfunction

    task automatic model_reset();
        mode = M_CPU; age = 0; idle_left = 0;
        for (int i = 0; i < SYNC_STAGES; i++) begin br_d[i] = 0; bg_d[i] = 0; end
        {e_bgl, e_hold, e_own} = mode_pins(M_CPU);
        e_tmo = 1'b0;
    endtask

    task automatic model_step();
        bit br, bg;
        br = br_d[SYNC_STAGES-1];
        bg = bg_d[SYNC_STAGES-1];
        e_tmo = 1'b0;
        case (mode)
            M_CPU: if (br) begin
                mode = bg ? M_OTHER : (cpu_busy ? M_CPU_HELD : M_GRANTED);
                age = 0;
            end
            M_CPU_HELD: if (!br) mode = M_CPU; else if (!cpu_busy) begin mode = M_GRANTED; age = 0; end
            M_GRANTED: if (bg) mode = M_OTHER; else if (!br) mode = M_CPU; else begin
                age++;
`ifdef BGCTL_TIMEOUT_EN
                if (age == BG_TIMEOUT) begin mode = M_CPU; e_tmo = 1'b1; end
`endif
            end
            M_OTHER: if (!bg) begin mode = M_RECOVER; idle_left = RECOVER_CYC; end
            default: begin
                idle_left--;
                if (idle_left == 0) begin mode = br ? M_GRANTED : M_CPU; age = 0; end
            end
        endcase
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin br_d[i] = br_d[i-1]; bg_d[i] = bg_d[i-1]; end
        br_d[0] = !brl;
        bg_d[0] = !bgackl;
        {e_bgl, e_hold, e_own} = mode_pins(mode);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic test_reset();
        resetl = 1'b0; brl = 1'b1; bgackl = 1'b1; cpu_busy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bgl, cpu_hold, cpu_own, tmo_obs} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_values: bgl/hold/own/tmo=%b%b%b%b expected 1010", bgl, cpu_hold, cpu_own, tmo_obs);
        end
        resetl = 1'b1;
    endtask

    task automatic test_idle_grant();
        brl = 1'b0;
        tick(2);
        n_checks++;
        if (bgl !== 1'b1) begin n_fail++; $display("FAIL idle_grant_early: bgl=%b expected 1", bgl); end
        tick(1);
        n_checks++;
        if ({bgl, cpu_hold, cpu_own} !== 3'b010) begin
            n_fail++; $display("FAIL idle_grant_edge3: bgl/hold/own=%b%b%b expected 010", bgl, cpu_hold, cpu_own);
        end
        tick(4);
        bgackl = 1'b0;
        tick(2);
        n_checks++;
        if (bgl !== 1'b0) begin n_fail++; $display("FAIL idle_ack_early: bgl=%b expected 0", bgl); end
        tick(1);
        n_checks++;
        if ({bgl, cpu_hold, cpu_own} !== 3'b110) begin
            n_fail++; $display("FAIL idle_ack_edge3: bgl/hold/own=%b%b%b expected 110", bgl, cpu_hold, cpu_own);
        end
    endtask

    task automatic test_release();
        brl = 1'b1; bgackl = 1'b1;
        tick(5);
        n_checks++;
        if (cpu_own !== 1'b0) begin n_fail++; $display("FAIL release_early: cpu_own=%b expected 0", cpu_own); end
        tick(1);
        n_checks++;
        if ({cpu_hold, cpu_own} !== 2'b01) begin
            n_fail++; $display("FAIL release_edge6: hold/own=%b%b expected 01", cpu_hold, cpu_own);
        end
    endtask

    task automatic test_busy();
        cpu_busy = 1'b1; brl = 1'b0;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bgl, cpu_hold, cpu_own} !== 3'b111) begin
                n_fail++; $display("FAIL busy_wait[%0d]: bgl/hold/own=%b%b%b expected 111", i, bgl, cpu_hold, cpu_own);
            end
            tick(1);
        end
        cpu_busy = 1'b0;
        tick(1);
        n_checks++;
        if ({bgl, cpu_own} !== 2'b00) begin
            n_fail++; $display("FAIL busy_grant: bgl/own=%b%b expected 00", bgl, cpu_own);
        end
        brl = 1'b1;
        tick(3);
        n_checks++;
        if ({bgl, cpu_hold, cpu_own} !== 3'b101) begin
            n_fail++; $display("FAIL busy_withdraw: bgl/hold/own=%b%b%b expected 101", bgl, cpu_hold, cpu_own);
        end
    endtask

    task automatic test_chained();
        brl = 1'b0;
        tick(3);
        bgackl = 1'b0;
        tick(3);
        n_checks++;
        if ({bgl, cpu_hold, cpu_own} !== 3'b110) begin
            n_fail++; $display("FAIL chain_released: bgl/hold/own=%b%b%b expected 110", bgl, cpu_hold, cpu_own);
        end
        bgackl = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            n_checks++;
            if ({bgl, cpu_own} !== 2'b10) begin
                n_fail++; $display("FAIL chain_recover[%0d]: bgl/own=%b%b expected 10", i, bgl, cpu_own);
            end
        end
        tick(1);
        n_checks++;
        if ({bgl, cpu_hold, cpu_own} !== 3'b010) begin
            n_fail++; $display("FAIL chain_regrant: bgl/hold/own=%b%b%b expected 010", bgl, cpu_hold, cpu_own);
        end
        brl = 1'b1;
        tick(3);
    endtask

    task automatic test_withdraw();
        brl = 1'b0;
        tick(3);
        brl = 1'b1;
        tick(2);
        n_checks++;
        if (bgl !== 1'b0) begin n_fail++; $display("FAIL withdraw_hold: bgl=%b expected 0", bgl); end
        tick(1);
        n_checks++;
        if ({bgl, cpu_hold, cpu_own} !== 3'b101) begin
            n_fail++; $display("FAIL withdraw_own: bgl/hold/own=%b%b%b expected 101", bgl, cpu_hold, cpu_own);
        end
    endtask

    task automatic test_preowned();
        brl = 1'b0; bgackl = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            n_checks++;
            if (bgl !== 1'b1) begin n_fail++; $display("FAIL preowned_bgl[%0d]: bgl=%b expected 1", i, bgl); end
        end
        n_checks++;
        if ({cpu_hold, cpu_own} !== 2'b10) begin
            n_fail++; $display("FAIL preowned_released: hold/own=%b%b expected 10", cpu_hold, cpu_own);
        end
        brl = 1'b1; bgackl = 1'b1;
        tick(6);
        n_checks++;
        if ({bgl, cpu_hold, cpu_own} !== 3'b101) begin
            n_fail++; $display("FAIL preowned_back: bgl/hold/own=%b%b%b expected 101", bgl, cpu_hold, cpu_own);
        end
    endtask

`ifdef BGCTL_TIMEOUT_EN
    task automatic test_timeout();
        brl = 1'b0;
        tick(3);
        for (int i = 1; i < BG_TIMEOUT; i++) begin
            tick(1);
            n_checks++;
            if ({tmo, bgl} !== 2'b00) begin
                n_fail++; $display("FAIL timeout_wait[%0d]: tmo/bgl=%b%b expected 00", i, tmo, bgl);
            end
        end
        tick(1);
        n_checks++;
        if ({tmo, bgl, cpu_own} !== 3'b111) begin
            n_fail++; $display("FAIL timeout_fire: tmo/bgl/own=%b%b%b expected 111", tmo, bgl, cpu_own);
        end
        tick(1);
        n_checks++;
        if ({tmo, bgl} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_regrant: tmo/bgl=%b%b expected 00", tmo, bgl);
        end
        brl = 1'b1;
        tick(3);
    endtask
`endif

    task automatic test_reset_mid_grant();
        brl = 1'b0;
        tick(3);
        n_checks++;
        if (bgl !== 1'b0) begin n_fail++; $display("FAIL midreset_granted: bgl=%b expected 0", bgl); end
        resetl = 1'b0;
        #1;
        n_checks++;
        if ({bgl, cpu_hold, cpu_own, tmo_obs} !== 4'b1010) begin
            n_fail++; $display("FAIL midreset_now: bgl/hold/own/tmo=%b%b%b%b expected 1010", bgl, cpu_hold, cpu_own, tmo_obs);
        end
        model_reset();
        brl = 1'b1;
        @(posedge clk);
        #1;
        resetl = 1'b1;
        tick(1);
        n_checks++;
        if ({bgl, cpu_hold, cpu_own} !== 3'b101) begin
            n_fail++; $display("FAIL midreset_after: bgl/hold/own=%b%b%b expected 101", bgl, cpu_hold, cpu_own);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) brl = ~brl;
            if ($urandom_range(9) == 0) bgackl = ~bgackl;
            if (!bgl && $urandom_range(5) == 0) bgackl = 1'b0;
            cpu_busy = ($urandom_range(2) == 0);
            tick(1);
            n_checks++;
            if ({bgl, cpu_hold, cpu_own, tmo_obs} !== {e_bgl, e_hold, e_own, e_tmo}) begin
                n_fail++;
                $display("FAIL random[%0d]: bgl/hold/own/tmo=%b%b%b%b expected %b%b%b%b", c,
                         bgl, cpu_hold, cpu_own, tmo_obs, e_bgl, e_hold, e_own, e_tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_grant();
        test_release();
        test_busy();
        test_chained();
        test_withdraw();
        test_preowned();
`ifdef BGCTL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
